// File: rtl/sd_route_pkg.sv
// Shared types and defaults for the SD routing controller.
package sd_route_pkg;

  localparam int SD_IDX_W             = 2;
  localparam int DEF_ACT_TIMEOUT      = 1000000;
  localparam int DEF_MOUNT_RST_CYCLES = 10000000;

  typedef struct packed {
    logic                virt;
    logic [SD_IDX_W-1:0] idx;
  } sd_target_t;

  localparam sd_target_t SD_TGT_PHYS = '{virt: 1'b0, idx: '0};

endpackage

// File: rtl/sd_act_stretch.sv
// Activity stretcher: an edge clears a saturating counter and o_act stays high
// for TIMEOUT cycles after the last edge (high one cycle after the edge).
module sd_act_stretch
  import sd_route_pkg::*;
#(
  parameter int TIMEOUT = DEF_ACT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_edge,
  output logic o_act
);

  localparam int            CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_act;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_edge) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != MAX) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= MAX;
      r_act <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_act <= (w_cnt_nxt < MAX);
    end
  end

  assign o_act = r_act;

endmodule

// File: rtl/sd_route_ctrl.sv
// Routes the core SPI SD master to the physical slot or one of NUM_IMG virtual images.
// Mount events are queued in a pending register and only committed while chip-select is idle.
module sd_route_ctrl
  import sd_route_pkg::*;
#(
  parameter int NUM_IMG          = 2,
  parameter int ACT_TIMEOUT      = DEF_ACT_TIMEOUT,
  parameter int MOUNT_RST_CYCLES = DEF_MOUNT_RST_CYCLES,
  parameter int IDX_W            = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic               i_clk_sys,
  input  logic               i_reset_n,
  input  logic [NUM_IMG-1:0] i_img_mounted,
  input  logic [NUM_IMG-1:0] i_img_nonzero,
  input  logic               i_spi_sck,
  input  logic               i_spi_mosi,
  input  logic               i_spi_ss_n,
  input  logic               i_phys_miso,
  input  logic [NUM_IMG-1:0] i_vsd_miso,
  output logic               o_core_miso,
  output logic [NUM_IMG-1:0] o_vsd_ss_n,
  output logic               o_phys_cs_n,
  output logic               o_phys_sck,
  output logic               o_phys_mosi,
  output logic               o_sel_virt,
  output logic [IDX_W-1:0]   o_sel_idx,
  output logic               o_reset_req,
  output logic               o_act_phys,
  output logic               o_act_virt
);

  localparam int            RW       = $clog2(MOUNT_RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(MOUNT_RST_CYCLES - 1);

  sd_target_t    r_sel;
  sd_target_t    r_pend;
  logic          r_pend_vld;
  logic [RW-1:0] r_rst_cnt;
  logic          r_reset_req;
  logic          r_prev_mosi;
  logic          r_prev_miso;

  logic          w_mnt_any;
  sd_target_t    w_mnt_tgt;
  logic          w_vsd_miso;
  logic          w_any_edge;

  // Descending scan so the lowest mounted index has the final say.
  always_comb begin
    w_mnt_any = |i_img_mounted;
    w_mnt_tgt = r_sel;
    for (int i = NUM_IMG - 1; i >= 0; i--) begin
      if (i_img_mounted[i]) begin
        if (i_img_nonzero[i]) begin
          w_mnt_tgt = '{virt: 1'b1, idx: SD_IDX_W'(i)};
        end else if (r_sel.virt && (r_sel.idx == SD_IDX_W'(i))) begin
          w_mnt_tgt = SD_TGT_PHYS;
        end else begin
          w_mnt_tgt = r_sel;
        end
      end
    end
  end

  always_comb begin
    o_vsd_ss_n = '1;
    w_vsd_miso = 1'b0;
    for (int i = 0; i < NUM_IMG; i++) begin
      o_vsd_ss_n[i] = ~(r_sel.virt && (r_sel.idx == SD_IDX_W'(i))) | i_spi_ss_n;
      if (r_sel.idx == SD_IDX_W'(i)) begin
        w_vsd_miso = i_vsd_miso[i];
      end
    end
  end

  assign o_phys_cs_n = r_sel.virt | i_spi_ss_n;
  assign o_phys_sck  = i_spi_sck & ~o_phys_cs_n;
  assign o_phys_mosi = i_spi_mosi & ~o_phys_cs_n;
  assign o_core_miso = r_sel.virt ? w_vsd_miso : i_phys_miso;
  assign o_sel_virt  = r_sel.virt;
  assign o_sel_idx   = r_sel.idx[IDX_W-1:0];
  assign o_reset_req = r_reset_req;

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sel       <= SD_TGT_PHYS;
      r_pend      <= SD_TGT_PHYS;
      r_pend_vld  <= 1'b0;
      r_rst_cnt   <= '0;
      r_reset_req <= 1'b0;
      r_prev_mosi <= 1'b0;
      r_prev_miso <= 1'b0;
    end else begin
      r_prev_mosi <= i_spi_mosi;
      r_prev_miso <= o_core_miso;
      if (w_mnt_any) begin
        r_pend      <= w_mnt_tgt;
        r_pend_vld  <= 1'b1;
        r_rst_cnt   <= RST_LOAD;
        r_reset_req <= 1'b1;
      end else begin
        if (r_pend_vld && i_spi_ss_n) begin
          r_sel      <= r_pend;
          r_pend_vld <= 1'b0;
        end
        if (r_rst_cnt != '0) begin
          r_rst_cnt <= r_rst_cnt - RW'(1);
        end
        r_reset_req <= (r_rst_cnt != '0);
      end
    end
  end

  assign w_any_edge = ~i_spi_ss_n &
                      ((i_spi_mosi ^ r_prev_mosi) | (o_core_miso ^ r_prev_miso));

  sd_act_stretch #(.TIMEOUT(ACT_TIMEOUT)) u_act_phys (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_reset_n),
    .i_edge  (w_any_edge & ~r_sel.virt),
    .o_act   (o_act_phys)
  );

  sd_act_stretch #(.TIMEOUT(ACT_TIMEOUT)) u_act_virt (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_reset_n),
    .i_edge  (w_any_edge & r_sel.virt),
    .o_act   (o_act_virt)
  );

endmodule

// File: tb/tb_sd_route_ctrl.sv
// Bench for sd_route_ctrl: directed scenarios then random traffic, all compared
// each cycle against a timestamp-based reference model.
module tb_sd_route_ctrl;

  localparam int NI  = 2;
  localparam int ACT = 8;
  localparam int MRC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] mounted, nonzero, vsd_miso, vsd_ss_n;
  logic          sck, mosi, ss_n, phys_miso;
  logic          core_miso, phys_cs_n, phys_sck, phys_mosi;
  logic          sel_virt, reset_req, act_phys, act_virt;
  logic [0:0]    sel_idx;

  int checks = 0;
  int failures = 0;

  // Reference model state: selection, pending target, and timestamps.
  int ecount = 0;
  int m_virt, m_idx, m_pv, m_pvirt, m_pidx;
  int m_req_until, m_last_p, m_last_v;
  logic m_prev_mosi, m_prev_miso;

  sd_route_ctrl #(.NUM_IMG(NI), .ACT_TIMEOUT(ACT), .MOUNT_RST_CYCLES(MRC)) dut (
    .i_clk_sys     (clk),
    .i_reset_n     (rst_n),
    .i_img_mounted (mounted),
    .i_img_nonzero (nonzero),
    .i_spi_sck     (sck),
    .i_spi_mosi    (mosi),
    .i_spi_ss_n    (ss_n),
    .i_phys_miso   (phys_miso),
    .i_vsd_miso    (vsd_miso),
    .o_core_miso   (core_miso),
    .o_vsd_ss_n    (vsd_ss_n),
    .o_phys_cs_n   (phys_cs_n),
    .o_phys_sck    (phys_sck),
    .o_phys_mosi   (phys_mosi),
    .o_sel_virt    (sel_virt),
    .o_sel_idx     (sel_idx),
    .o_reset_req   (reset_req),
    .o_act_phys    (act_phys),
    .o_act_virt    (act_virt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_core_miso();
    return (m_virt != 0) ? vsd_miso[m_idx] : phys_miso;
  endfunction

  task automatic model_reset();
    m_virt = 0; m_idx = 0; m_pv = 0; m_pvirt = 0; m_pidx = 0;
    m_req_until = 0; m_last_p = -1000; m_last_v = -1000;
    m_prev_mosi = 1'b0; m_prev_miso = 1'b0;
  endtask

  task automatic model_update();
    logic cm;
    int   w, tv, ti;
    ecount++;
    if (!rst_n) begin
      model_reset();
    end else begin
      cm = m_core_miso();
      if (!ss_n && (mosi != m_prev_mosi || cm != m_prev_miso)) begin
        if (m_virt != 0) m_last_v = ecount;
        else             m_last_p = ecount;
      end
      m_prev_mosi = mosi;
      m_prev_miso = cm;
      w = -1;
      for (int i = NI - 1; i >= 0; i--) if (mounted[i]) w = i;
      if (w >= 0) begin
        if (nonzero[w]) begin tv = 1; ti = w; end
        else if (m_virt != 0 && m_idx == w) begin tv = 0; ti = 0; end
        else begin tv = m_virt; ti = m_idx; end
        m_pvirt = tv; m_pidx = ti; m_pv = 1;
        m_req_until = ecount + MRC;
      end else if (m_pv != 0 && ss_n) begin
        m_virt = m_pvirt; m_idx = m_pidx; m_pv = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [NI-1:0] ev;
    logic          ecs;
    for (int i = 0; i < NI; i++) ev[i] = !(m_virt != 0 && m_idx == i) || ss_n;
    ecs = (m_virt != 0) || ss_n;
    chk("sel_virt", sel_virt, m_virt);
    chk("sel_idx", sel_idx, m_idx);
    chk("reset_req", reset_req, ecount < m_req_until);
    chk("act_phys", act_phys, (ecount - m_last_p) < ACT);
    chk("act_virt", act_virt, (ecount - m_last_v) < ACT);
    chk("core_miso", core_miso, m_core_miso());
    chk("vsd_ss_n", vsd_ss_n, ev);
    chk("phys_cs_n", phys_cs_n, ecs);
    chk("phys_sck", phys_sck, sck & ~ecs);
    chk("phys_mosi", phys_mosi, mosi & ~ecs);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  int n;

  initial begin
    rst_n = 1'b0; mounted = '0; nonzero = '0; vsd_miso = '0;
    sck = 1'b0; mosi = 1'b0; ss_n = 1'b1; phys_miso = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    ss_n = 1'b0; step();
    ss_n = 1'b1; step();

    // Mount image0 with chip-select idle; measure reset request length.
    mounted = 2'b01; nonzero = 2'b01;
    step();
    mounted = '0;
    n = reset_req ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (reset_req) n++;
      else break;
    end
    chk("req_len", n, MRC);
    ss_n = 1'b0; sck = 1'b1; mosi = 1'b1; step();
    sck = 1'b0; step();
    ss_n = 1'b1; step();

    // Mount image1 during an active transfer: switch waits for ss_n high.
    ss_n = 1'b0; mounted = 2'b10; nonzero = 2'b10;
    step();
    mounted = '0;
    repeat (10) step();
    chk("deferred_hold_idx", sel_idx, 0);
    ss_n = 1'b1;
    repeat (2) step();
    chk("deferred_idx", sel_idx, 1);

    // Simultaneous mounts; then a retrigger partway through the reset window.
    mounted = 2'b11; nonzero = 2'b11;
    step();
    mounted = '0;
    repeat (4) step();
    mounted = 2'b01; nonzero = 2'b01;
    step();
    mounted = '0;
    n = reset_req ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (reset_req) n++;
      else break;
    end
    chk("req_retrig_len", n, MRC);
    chk("multi_sel_idx", sel_idx, 0);

    // Unmount inactive image1, then the active image0.
    mounted = 2'b10; nonzero = 2'b00;
    step();
    chk("unmount_req", reset_req, 1);
    mounted = '0;
    repeat (2) step();
    chk("unmount_inactive_virt", sel_virt, 1);
    mounted = 2'b01; nonzero = 2'b00;
    step();
    mounted = '0;
    repeat (2) step();
    chk("unmount_active_virt", sel_virt, 0);
    mounted = 2'b01; nonzero = 2'b01;
    step();
    mounted = '0;
    repeat (20) step();

    // Single MOSI edge on the virtual target; then reset mid-stretch.
    ss_n = 1'b0; step();
    mosi = ~mosi; step();
    n = act_virt ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (act_virt) n++;
    end
    chk("stretch_len", n, ACT);
    mosi = ~mosi; step();
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_act_virt", act_virt, 0);
    step();
    rst_n = 1'b1; ss_n = 1'b1;
    step();

    for (int k = 0; k < 600; k++) begin
      mounted   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      nonzero   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ss_n = ~ss_n;
      sck       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mosi = ~mosi;
      phys_miso = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) vsd_miso = 2'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
